sa_autosa_sdp_rd_arb: RTL and testbench
=======================================

// Module: sa_autosa_sdp_rd_arb
// PURPOSE
//  Merges the three SDP read-request streams (0=mrdma, 1=brdma, 2=nrdma) onto one MCIF read port.
//  Round-robin arbitration; an in-order tag FIFO routes MCIF read-response beats back to the owner.
//  Sits between SA_AUTOSA_sdp and the MCIF read client inside partition P.
//  Credit/latency-FIFO pop signals bypass this block.
// PARAMETERS
//  AW         32   address field width, req pd[AW-1:0]
//  SW         15   size field width, req pd[AW+SW-1:AW]; beats = size+1
//  RSP_W      65   response pd width (64 data + 1 mask)
//  ORD_DEPTH  8    outstanding-request tag FIFO depth; power of 2, >=2
// PORTS
//  autosa_core_clk    in   1             core clock
//  autosa_core_rstn   in   1             async active-low reset
//  req_valid          in   3             per-requester request valid, bit i = requester i
//  req_ready          out  3             per-requester request accept
//  req_pd             in   3*(AW+SW)     requester i at [i*(AW+SW) +: AW+SW]
//  arb2mcif_rd_req_valid  out  1         merged request valid
//  arb2mcif_rd_req_ready  in   1         MCIF accept
//  arb2mcif_rd_req_pd     out  AW+SW     merged request payload, unmodified
//  mcif2arb_rd_rsp_valid  in   1         response beat valid
//  mcif2arb_rd_rsp_ready  out  1         response beat accept
//  mcif2arb_rd_rsp_pd     in   RSP_W     response beat
//  rsp_valid          out  3             per-requester response valid
//  rsp_ready          in   3             per-requester response accept
//  rsp_pd             out  RSP_W         shared response payload, equal to mcif2arb_rd_rsp_pd
//  ord_full / ord_empty  out  1          tag FIFO status
// BEHAVIOUR
//  Reset: all valids/readies 0, arb2mcif pd 0, RR pointer -> requester 0 highest priority.
//  Reset: tag FIFO empty (ord_empty=1, ord_full=0), beat counter 0. Reset mid-transfer drops all outstanding state.
//  Output stage: 1 register. can_grant = (!out_valid | arb2mcif_rd_req_ready) & !ord_full.
//  Arbitration: on can_grant, pick the first valid requester starting at ptr. req_ready is one-hot to that requester only.
//  Arbitration: on grant, ptr <= winner+1 mod 3. No valid requester -> ptr unchanged.
//  Latency: request accepted in cycle N is presented on arb2mcif in N+1.
//  Output hold: pd/valid held stable while valid & !ready.
//  Tag FIFO: on grant, push {id[1:0], size[SW-1:0]}.
//  Tag FIFO full: push blocked even if a pop occurs the same cycle. Simultaneous push+pop when not full is legal; count unchanged.
//  Response routing: head entry selects dest id.
//    rsp_valid[id] = mcif valid & !ord_empty.
//    mcif2arb_rd_rsp_ready = !ord_empty & rsp_ready[id].
//    Other rsp_valid bits = 0. Combinational path, zero added latency.
//  Beat counter (SW+1 bits): increments per accepted beat. Beat == head.size is the final beat: pop FIFO, counter -> 0.
//  size=0: single beat. size=2^SW-1: 2^SW beats, no counter overflow.
//  Response beats with empty FIFO: ready held 0 (stall, beat never dropped).
// CONFIGURATION
//  SA_AUTOSA_RD_ARB_STALL_CNT_EN defined: adds
//    stall_cnt_clr in 1
//    stall_cnt     out 3*32
//  Per requester: saturating 32-bit count of cycles with req_valid[i] & !req_ready[i].
//  Reset/clr -> 0; clr wins over increment. Counters stick at 32'hFFFF_FFFF.
//  SA_AUTOSA_RD_ARB_STALL_CNT_EN undefined: those ports and counters absent; all other behaviour identical.
// TESTING
//  T1: req1 only, size=2, addr=0x1000; MCIF ready=1.
//      -> arb pd valid next cycle; 3 rsp beats routed only to rsp_valid[1]; ord_empty=1 after 3rd beat.
//  T2: req_valid=3'b111 held, MCIF ready=1.
//      -> grants 0,1,2,0,1,2 on consecutive cycles.
//  T3: MCIF ready=0 with pending output.
//      -> req_ready=0, arb2mcif pd/valid stable until ready returns.
//  T4: 8 size=0 requests, no responses.
//      -> ord_full=1, 9th blocked; 1 beat returned -> 9th granted the following cycle.
//  T5: head id=2, rsp_ready[2]=0, MCIF beat valid.
//      -> mcif2arb_rd_rsp_ready=0, beat held; rsp_ready[2]=1 -> accepted.
//  T6 (macro): req0 blocked 5 cycles -> stall_cnt[31:0]=5; clr -> 0.

Source files
------------

// File: rtl/sa_autosa_sdp_rd_arb.sv
// sa_autosa_sdp_rd_arb
//  Merges the mrdma(0)/brdma(1)/nrdma(2) SDP read-request streams onto a single
//  MCIF read port with round-robin arbitration. An in-order tag FIFO remembers
//  {requester id, size} for every granted request so the MCIF response beats
//  can be steered back to their owner with no added latency.
//
//  Optional feature macro: SA_AUTOSA_RD_ARB_STALL_CNT_EN
//   When defined, adds stall_cnt_clr / stall_cnt: one saturating 32-bit counter
//   per requester, counting cycles where req_valid[i] & !req_ready[i].
//
//  Handshake rule for every valid/ready pair in this block: a transfer happens
//  on a rising clock edge where valid and ready are both 1; a producer holding
//  valid keeps its payload stable until that edge. req_ready and
//  mcif2arb_rd_rsp_ready may depend combinationally on the matching valid.
module sa_autosa_sdp_rd_arb #(
  parameter int AW        = 32,
  parameter int SW        = 15,
  parameter int RSP_W     = 65,
  parameter int ORD_DEPTH = 8
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rstn,
  input  logic [2:0]             req_valid,
  output logic [2:0]             req_ready,
  input  logic [3*(AW+SW)-1:0]   req_pd,
  output logic                   arb2mcif_rd_req_valid,
  input  logic                   arb2mcif_rd_req_ready,
  output logic [AW+SW-1:0]       arb2mcif_rd_req_pd,
  input  logic                   mcif2arb_rd_rsp_valid,
  output logic                   mcif2arb_rd_rsp_ready,
  input  logic [RSP_W-1:0]       mcif2arb_rd_rsp_pd,
  output logic [2:0]             rsp_valid,
  input  logic [2:0]             rsp_ready,
  output logic [RSP_W-1:0]       rsp_pd,
  output logic                   ord_full,
  output logic                   ord_empty
`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
  ,
  input  logic                   stall_cnt_clr,
  output logic [3*32-1:0]        stall_cnt
`endif
);

  localparam int PW  = AW + SW;
  localparam int TW  = 2 + SW;
  localparam int OAW = $clog2(ORD_DEPTH);

  // Request side
  logic [1:0]    ptr;
  logic [1:0]    win_id;
  logic          win_found;
  logic          can_grant;
  logic          grant;
  logic [PW-1:0] win_pd;
  logic          out_valid;
  logic [PW-1:0] out_pd;

  // Tag FIFO
  logic [TW-1:0] ord_mem [ORD_DEPTH];
  logic [OAW:0]  wr_ptr;
  logic [OAW:0]  rd_ptr;
  logic [TW-1:0] head;
  logic [1:0]    head_id;
  logic [SW-1:0] head_size;

  // Response side
  logic [SW:0]   beat_cnt;
  logic          head_ready;
  logic          rsp_fire;
  logic          last_beat;

  assign ord_empty = (wr_ptr == rd_ptr);
  assign ord_full  = (wr_ptr[OAW] != rd_ptr[OAW]) &&
                     (wr_ptr[OAW-1:0] == rd_ptr[OAW-1:0]);

  // A grant needs room in the output register and a free tag slot; a pop in
  // the same cycle does not free the slot early.
  assign can_grant = (!out_valid || arb2mcif_rd_req_ready) && !ord_full;
  assign grant     = can_grant && win_found;

  // Round-robin search starting at ptr
  always_comb begin
    logic [2:0] cand;
    win_found = 1'b0;
    win_id    = ptr;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_found && req_valid[cand[1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[1:0];
      end
    end
  end

  // Winner payload and one-hot accept
  always_comb begin
    win_pd    = '0;
    req_ready = 3'b000;
    case (win_id)
      2'd0:    win_pd = req_pd[0*PW +: PW];
      2'd1:    win_pd = req_pd[1*PW +: PW];
      default: win_pd = req_pd[2*PW +: PW];
    endcase
    if (grant) req_ready = 3'b001 << win_id;
  end

  // Pointer update and single output register stage
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      ptr       <= 2'd0;
      out_valid <= 1'b0;
      out_pd    <= '0;
    end else begin
      if (grant) begin
        ptr       <= (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
        out_valid <= 1'b1;
        out_pd    <= win_pd;
      end else if (arb2mcif_rd_req_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign arb2mcif_rd_req_valid = out_valid;
  assign arb2mcif_rd_req_pd    = out_pd;

  // Tag storage; contents need no reset because the pointers define validity
  always_ff @(posedge autosa_core_clk) begin
    if (grant) ord_mem[wr_ptr[OAW-1:0]] <= {win_id, win_pd[PW-1:AW]};
  end

  assign head      = ord_mem[rd_ptr[OAW-1:0]];
  assign head_id   = head[TW-1:SW];
  assign head_size = head[SW-1:0];

  // Steer the response beat to the head owner
  always_comb begin
    head_ready = 1'b0;
    rsp_valid  = 3'b000;
    case (head_id)
      2'd0:    head_ready = rsp_ready[0];
      2'd1:    head_ready = rsp_ready[1];
      2'd2:    head_ready = rsp_ready[2];
      default: head_ready = 1'b0;
    endcase
    if (mcif2arb_rd_rsp_valid && !ord_empty) rsp_valid = 3'b001 << head_id;
  end

  assign mcif2arb_rd_rsp_ready = !ord_empty && head_ready;
  assign rsp_pd    = mcif2arb_rd_rsp_pd;
  assign rsp_fire  = mcif2arb_rd_rsp_valid && mcif2arb_rd_rsp_ready;
  assign last_beat = (beat_cnt == {1'b0, head_size});

  // FIFO pointers and per-request beat counter
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (rsp_fire) begin
        if (last_beat) begin
          rd_ptr   <= rd_ptr + 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
  logic [31:0] stall_q [3];

  // Saturating stall counters; clear has priority over counting
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      for (int i = 0; i < 3; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stall_cnt_clr)
          stall_q[i] <= '0;
        else if (req_valid[i] && !req_ready[i] && (stall_q[i] != 32'hFFFF_FFFF))
          stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

  assign stall_cnt = {stall_q[2], stall_q[1], stall_q[0]};
`endif

endmodule

// File: tb/tb_sa_autosa_sdp_rd_arb.sv
// tb_sa_autosa_sdp_rd_arb
//  Directed scenarios for the SDP read arbiter: reset state, single request
//  with routed response beats, round-robin order, output hold under MCIF
//  backpressure, tag FIFO full, response backpressure, maximum size request
//  and (with SA_AUTOSA_RD_ARB_STALL_CNT_EN) the stall counters.
module tb_sa_autosa_sdp_rd_arb;

  localparam int AW        = 32;
  localparam int SW        = 15;
  localparam int RSP_W     = 65;
  localparam int ORD_DEPTH = 8;
  localparam int PW        = AW + SW;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [3*PW-1:0]   req_pd;
  logic              arb_valid;
  logic              arb_ready;
  logic [PW-1:0]     arb_pd;
  logic              mrsp_valid;
  logic              mrsp_ready;
  logic [RSP_W-1:0]  mrsp_pd;
  logic [2:0]        rsp_valid;
  logic [2:0]        rsp_ready;
  logic [RSP_W-1:0]  rsp_pd;
  logic              ord_full;
  logic              ord_empty;
`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
  logic              stall_clr;
  logic [95:0]       stall_cnt;
`endif

  sa_autosa_sdp_rd_arb #(
    .AW(AW), .SW(SW), .RSP_W(RSP_W), .ORD_DEPTH(ORD_DEPTH)
  ) dut (
    .autosa_core_clk       (clk),
    .autosa_core_rstn      (rst_n),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_pd                (req_pd),
    .arb2mcif_rd_req_valid (arb_valid),
    .arb2mcif_rd_req_ready (arb_ready),
    .arb2mcif_rd_req_pd    (arb_pd),
    .mcif2arb_rd_rsp_valid (mrsp_valid),
    .mcif2arb_rd_rsp_ready (mrsp_ready),
    .mcif2arb_rd_rsp_pd    (mrsp_pd),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_pd                (rsp_pd),
    .ord_full              (ord_full),
    .ord_empty             (ord_empty)
`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
    ,
    .stall_cnt_clr         (stall_clr),
    .stall_cnt             (stall_cnt)
`endif
  );

  // Scoreboard
  logic [PW-1:0]    exp_q[$];
  logic [RSP_W-1:0] rsp_q[$];
  logic [1:0]       id_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [PW-1:0] make_pd(input logic [SW-1:0] size, input logic [AW-1:0] addr);
    return {size, addr};
  endfunction

  function automatic logic [RSP_W-1:0] rand_rsp();
    logic [RSP_W-1:0] v;
    v[31:0]  = $urandom;
    v[63:32] = $urandom;
    v[64]    = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [PW-1:0] pd);
    req_pd[i*PW +: PW] = pd;
  endtask

  task automatic idle_inputs();
    req_valid  = 3'b000;
    req_pd     = '0;
    arb_ready  = 1'b0;
    mrsp_valid = 1'b0;
    mrsp_pd    = '0;
    rsp_ready  = 3'b000;
`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
    stall_clr  = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    rsp_q.delete();
    id_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mrsp_valid = 1'b1;
    rsp_ready  = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (arb_valid !== 1'b0 || arb_pd !== '0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_req: valid=%b pd=%h ready=%b expected 0/0/0", arb_valid, arb_pd, req_ready);
    end
    checks++;
    if (ord_empty !== 1'b1 || ord_full !== 1'b0) begin
      errors++; $display("FAIL reset_ord: empty=%b full=%b expected 1/0", ord_empty, ord_full);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mrsp_ready !== 1'b0 || rsp_valid !== 3'b000) begin
      errors++; $display("FAIL empty_stall: mrsp_ready=%b rsp_valid=%b expected 0/000", mrsp_ready, rsp_valid);
    end
    idle_inputs();
  endtask

  task automatic test_single();
    logic [PW-1:0]    e;
    logic [RSP_W-1:0] r;
    apply_reset();
    arb_ready = 1'b1;
    rsp_ready = 3'b111;
    set_req(1, make_pd(15'd2, 32'h1000));
    req_valid = 3'b010;
    exp_q.push_back(make_pd(15'd2, 32'h1000));
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready: got %b expected 010", req_ready);
    end
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (arb_valid !== 1'b1 || arb_pd !== e) begin
      errors++; $display("FAIL single_out: valid=%b pd=%h expected 1/%h", arb_valid, arb_pd, e);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      mrsp_valid = 1'b1;
      mrsp_pd    = rand_rsp();
      rsp_q.push_back(mrsp_pd);
      @(negedge clk);
      r = rsp_q.pop_front();
      checks++;
      if (rsp_valid !== 3'b010 || rsp_pd !== r || mrsp_ready !== 1'b1 || ord_empty !== 1'b0) begin
        errors++; $display("FAIL single_beat%0d: rsp_valid=%b pd=%h ready=%b empty=%b expected 010/%h/1/0",
                           b, rsp_valid, rsp_pd, mrsp_ready, ord_empty, r);
      end
    end
    tick();
    mrsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ord_empty !== 1'b1 || arb_valid !== 1'b0) begin
      errors++; $display("FAIL single_done: empty=%b arb_valid=%b expected 1/0", ord_empty, arb_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [PW-1:0] pdv [3];
    logic [PW-1:0] e;
    logic [1:0]    eid;
    apply_reset();
    arb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pdv[i] = make_pd(15'd0, $urandom);
      set_req(i, pdv[i]);
    end
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(pdv[c % 3]);
      id_q.push_back(2'(c % 3));
    end
    req_valid = 3'b111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) begin
        eid = id_q.pop_front();
        checks++;
        if (req_ready !== (3'b001 << eid)) begin
          errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, 3'b001 << eid);
        end
      end
      if (c > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (arb_valid !== 1'b1 || arb_pd !== e) begin
          errors++; $display("FAIL rr_out%0d: valid=%b pd=%h expected 1/%h", c, arb_valid, arb_pd, e);
        end
      end
      tick();
      if (c == 5) req_valid = 3'b000;
    end
  endtask

  task automatic test_hold();
    logic [PW-1:0] pa, pb, e;
    apply_reset();
    pa = make_pd(15'($urandom), $urandom);
    pb = make_pd(15'($urandom), $urandom);
    set_req(0, pa);
    req_valid = 3'b001;
    exp_q.push_back(pa);
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL hold_first: got %b expected 001", req_ready);
    end
    tick();
    set_req(1, pb);
    req_valid = 3'b011;
    exp_q.push_back(pb);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b000 || arb_valid !== 1'b1 || arb_pd !== pa) begin
        errors++; $display("FAIL hold_cycle%0d: ready=%b valid=%b pd=%h expected 000/1/%h", c, req_ready, arb_valid, arb_pd, pa);
      end
      tick();
    end
    arb_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (arb_valid !== 1'b1 || arb_pd !== e || req_ready !== 3'b010) begin
      errors++; $display("FAIL hold_release: valid=%b pd=%h ready=%b expected 1/%h/010", arb_valid, arb_pd, req_ready, e);
    end
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (arb_valid !== 1'b1 || arb_pd !== e) begin
      errors++; $display("FAIL hold_next: valid=%b pd=%h expected 1/%h", arb_valid, arb_pd, e);
    end
  endtask

  task automatic test_full();
    apply_reset();
    arb_ready = 1'b1;
    set_req(0, make_pd(15'd0, $urandom));
    req_valid = 3'b001;
    for (int c = 0; c < ORD_DEPTH; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 3'b001 || ord_full !== 1'b0) begin
        errors++; $display("FAIL full_fill%0d: ready=%b full=%b expected 001/0", c, req_ready, ord_full);
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (ord_full !== 1'b1 || req_ready !== 3'b000) begin
        errors++; $display("FAIL full_block%0d: full=%b ready=%b expected 1/000", c, ord_full, req_ready);
      end
      tick();
    end
    mrsp_valid = 1'b1;
    rsp_ready  = 3'b001;
    mrsp_pd    = rand_rsp();
    @(negedge clk);
    checks++;
    if (mrsp_ready !== 1'b1 || rsp_valid !== 3'b001 || req_ready !== 3'b000) begin
      errors++; $display("FAIL full_pop: mrsp_ready=%b rsp_valid=%b req_ready=%b expected 1/001/000",
                         mrsp_ready, rsp_valid, req_ready);
    end
    tick();
    mrsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ord_full !== 1'b0 || req_ready !== 3'b001) begin
      errors++; $display("FAIL full_regrant: full=%b ready=%b expected 0/001", ord_full, req_ready);
    end
    tick();
    req_valid = 3'b000;
  endtask

  task automatic test_rsp_backpressure();
    logic [RSP_W-1:0] x, r;
    apply_reset();
    arb_ready = 1'b1;
    set_req(2, make_pd(15'd1, $urandom));
    req_valid = 3'b100;
    tick();
    req_valid  = 3'b000;
    mrsp_valid = 1'b1;
    x          = rand_rsp();
    mrsp_pd    = x;
    rsp_q.push_back(x);
    rsp_ready  = 3'b011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mrsp_ready !== 1'b0 || rsp_valid !== 3'b100 || rsp_pd !== x) begin
        errors++; $display("FAIL rsp_hold%0d: ready=%b rsp_valid=%b pd=%h expected 0/100/%h", c, mrsp_ready, rsp_valid, rsp_pd, x);
      end
      tick();
    end
    rsp_ready = 3'b111;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      r = rsp_q.pop_front();
      checks++;
      if (mrsp_ready !== 1'b1 || rsp_valid !== 3'b100 || rsp_pd !== r || ord_empty !== 1'b0) begin
        errors++; $display("FAIL rsp_accept%0d: ready=%b rsp_valid=%b pd=%h empty=%b expected 1/100/%h/0",
                           b, mrsp_ready, rsp_valid, rsp_pd, ord_empty, r);
      end
      tick();
      mrsp_pd = rand_rsp();
      rsp_q.push_back(mrsp_pd);
    end
    mrsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ord_empty !== 1'b1) begin
      errors++; $display("FAIL rsp_done: empty=%b expected 1", ord_empty);
    end
  endtask

  task automatic test_max_size();
    int early;
    apply_reset();
    arb_ready = 1'b1;
    rsp_ready = 3'b001;
    set_req(0, make_pd({SW{1'b1}}, $urandom));
    req_valid = 3'b001;
    tick();
    req_valid  = 3'b000;
    mrsp_valid = 1'b1;
    early = 0;
    for (int b = 0; b < (1 << SW); b++) begin
      @(negedge clk);
      if (ord_empty !== 1'b0 || mrsp_ready !== 1'b1 || rsp_valid !== 3'b001) early++;
      tick();
    end
    mrsp_valid = 1'b0;
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL max_beats: %0d beats not accepted for the request, expected 0", early);
    end
    @(negedge clk);
    checks++;
    if (ord_empty !== 1'b1) begin
      errors++; $display("FAIL max_done: empty=%b expected 1", ord_empty);
    end
  endtask

`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    apply_reset();
    set_req(1, make_pd(15'd0, $urandom));
    set_req(0, make_pd(15'd0, $urandom));
    req_valid = 3'b010;
    tick();
    req_valid = 3'b001;
    repeat (5) tick();
    req_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (stall_cnt[31:0] !== 32'd5 || stall_cnt[63:32] !== 32'd0) begin
      errors++; $display("FAIL stall_count: cnt0=%0d cnt1=%0d expected 5/0", stall_cnt[31:0], stall_cnt[63:32]);
    end
    tick();
    stall_clr = 1'b1;
    req_valid = 3'b001;
    tick();
    stall_clr = 1'b0;
    req_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("FAIL stall_clr: cnt=%h expected 0", stall_cnt);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_full();
    test_rsp_backpressure();
    test_max_size();
`ifdef SA_AUTOSA_RD_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
